// File: rtl/video_pattern_if.sv
// Video output bundle of the pattern generator: raster timing, pixel data and start-of-frame.
interface video_pattern_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  vs;
  logic                  hs;
  logic                  de;
  logic                  sof;
  logic [DATA_WIDTH-1:0] r;
  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] b;

  modport master (output vs, hs, de, sof, r, g, b);
  modport slave  (input  vs, hs, de, sof, r, g, b);
endinterface

// File: rtl/video_pattern_gen.sv
// Raster timing and RGB test-pattern source (solid, colour bars, ramp, 16x16 checker).
// Define PATTERN_GEN_SCROLL_EN to add a frame counter that scrolls the checker and offsets the ramp.
module video_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 12,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [1:0]            i_pattern_sel,
  input  logic [DATA_WIDTH-1:0] i_solid_r,
  input  logic [DATA_WIDTH-1:0] i_solid_g,
  input  logic [DATA_WIDTH-1:0] i_solid_b,
  video_pattern_if.master       o_vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_ACT    = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_ACT    = CNT_WIDTH'(V_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] HS_BEG   = CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CNT_WIDTH-1:0] HS_END   = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] VS_BEG   = CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CNT_WIDTH-1:0] VS_END   = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_WIDTH-1:0] BAR_LAST = CNT_WIDTH'(H_ACTIVE / 8 - 1);
  localparam logic [DATA_WIDTH-1:0] FULL    = '1;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [3*DATA_WIDTH-1:0] bar_rgb(input logic [2:0] idx);
    return {{DATA_WIDTH{~idx[1]}}, {DATA_WIDTH{~idx[2]}}, {DATA_WIDTH{~idx[0]}}};
  endfunction

  logic [CNT_WIDTH-1:0]    r_h_cnt, r_v_cnt, r_bar_cnt;
  logic [2:0]              r_bar_idx;
  logic [1:0]              r_sel;
  logic [DATA_WIDTH-1:0]   r_solid_r, r_solid_g, r_solid_b;
  logic                    r_vs_p1, r_hs_p1, r_de_p1, r_sof_p1;
  logic [DATA_WIDTH-1:0]   r_r_p1, r_g_p1, r_b_p1;
`ifdef PATTERN_GEN_SCROLL_EN
  logic [7:0]              r_frame;
  logic [4:0]              w_chk_x;
`endif

  logic                    w_origin, w_h_last, w_v_last, w_de, w_hs, w_vs, w_chk_hi;
  logic [1:0]              w_sel;
  logic [DATA_WIDTH-1:0]   w_solid_r, w_solid_g, w_solid_b, w_ramp;
  logic [CNT_WIDTH-1:0]    w_bar_cnt, w_bar_cnt_nxt;
  logic [2:0]              w_bar_idx, w_bar_idx_nxt;
  logic [3*DATA_WIDTH-1:0] w_px;

  always_comb begin
    w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_h_last = (r_h_cnt == H_LAST);
    w_v_last = (r_v_cnt == V_LAST);
    w_de     = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    w_hs     = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
    w_vs     = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
    // The origin pixel already shows the freshly sampled selection.
    w_sel     = w_origin ? i_pattern_sel : r_sel;
    w_solid_r = w_origin ? i_solid_r : r_solid_r;
    w_solid_g = w_origin ? i_solid_g : r_solid_g;
    w_solid_b = w_origin ? i_solid_b : r_solid_b;
    w_bar_cnt = (r_h_cnt == '0) ? '0 : r_bar_cnt;
    w_bar_idx = (r_h_cnt == '0) ? '0 : r_bar_idx;
    if (w_bar_cnt == BAR_LAST) begin
      w_bar_cnt_nxt = '0;
      w_bar_idx_nxt = w_bar_idx + 3'd1;
    end else begin
      w_bar_cnt_nxt = w_bar_cnt + CNT_WIDTH'(1);
      w_bar_idx_nxt = w_bar_idx;
    end
`ifdef PATTERN_GEN_SCROLL_EN
    w_ramp   = r_h_cnt[DATA_WIDTH-1:0] + DATA_WIDTH'(r_frame);
    w_chk_x  = r_h_cnt[4:0] + r_frame[4:0];
    w_chk_hi = (w_chk_x >= 5'd16);
`else
    w_ramp   = r_h_cnt[DATA_WIDTH-1:0];
    w_chk_hi = r_h_cnt[4];
`endif
    w_px = '0;
    if (w_de) begin
      case (w_sel)
        2'd0:    w_px = {w_solid_r, w_solid_g, w_solid_b};
        2'd1:    w_px = bar_rgb(w_bar_idx);
        2'd2:    w_px = {3{w_ramp}};
        default: w_px = (w_chk_hi ^ r_v_cnt[4]) ? '0 : {3{FULL}};
      endcase
    end
  end

  // Output stage p1: registered decode of the current counter position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_sel     <= '0;
      r_solid_r <= '0;
      r_solid_g <= '0;
      r_solid_b <= '0;
      r_vs_p1   <= 1'b0;
      r_hs_p1   <= 1'b0;
      r_de_p1   <= 1'b0;
      r_sof_p1  <= 1'b0;
      r_r_p1    <= '0;
      r_g_p1    <= '0;
      r_b_p1    <= '0;
`ifdef PATTERN_GEN_SCROLL_EN
      r_frame   <= '0;
`endif
    end else if (!i_en) begin
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
      r_vs_p1  <= 1'b0;
      r_hs_p1  <= 1'b0;
      r_de_p1  <= 1'b0;
      r_sof_p1 <= 1'b0;
      r_r_p1   <= '0;
      r_g_p1   <= '0;
      r_b_p1   <= '0;
    end else begin
      r_h_cnt   <= w_h_last ? '0 : r_h_cnt + CNT_WIDTH'(1);
      if (w_h_last) r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_WIDTH'(1);
`ifdef PATTERN_GEN_SCROLL_EN
      if (w_h_last && w_v_last) r_frame <= r_frame + 8'd1;
`endif
      r_bar_cnt <= w_bar_cnt_nxt;
      r_bar_idx <= w_bar_idx_nxt;
      r_sel     <= w_sel;
      r_solid_r <= w_solid_r;
      r_solid_g <= w_solid_g;
      r_solid_b <= w_solid_b;
      r_vs_p1   <= w_vs;
      r_hs_p1   <= w_hs;
      r_de_p1   <= w_de;
      r_sof_p1  <= w_de && w_origin;
      r_r_p1    <= w_px[3*DATA_WIDTH-1:2*DATA_WIDTH];
      r_g_p1    <= w_px[2*DATA_WIDTH-1:DATA_WIDTH];
      r_b_p1    <= w_px[DATA_WIDTH-1:0];
    end
  end

  assign o_vid.vs  = r_vs_p1;
  assign o_vid.hs  = r_hs_p1;
  assign o_vid.de  = r_de_p1;
  assign o_vid.sof = r_sof_p1;
  assign o_vid.r   = r_r_p1;
  assign o_vid.g   = r_g_p1;
  assign o_vid.b   = r_b_p1;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a 24x8 raster: per-cycle scoreboard plus directed timing/pattern checks.
module tb_video_pattern_gen;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic [1:0]    sel = 2'd0;
  logic [DW-1:0] sr = '0, sg = '0, sb = '0;

  video_pattern_if #(.DATA_WIDTH(DW)) vid ();

  video_pattern_gen #(
    .DATA_WIDTH(DW), .CNT_WIDTH(12),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(2)
  ) dut (
    .clk(clk), .rst(rst), .i_en(en), .i_pattern_sel(sel),
    .i_solid_r(sr), .i_solid_g(sg), .i_solid_b(sb),
    .o_vid(vid)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [27:0] exp_q[$];
  logic [27:0] obs;
  logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [23:0] cap[16];
  logic [23:0] line_a[16];

  assign obs = {vid.vs, vid.hs, vid.de, vid.sof, vid.r, vid.g, vid.b};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: pushes the output expected after each edge.
  int          m_h = 0, m_v = 0, m_f = 0;
  logic [1:0]  m_sel = 0;
  logic [23:0] m_solid = 0;
  always @(posedge clk) begin
    logic [27:0] e;
    logic [23:0] px;
    logic        de, hs, vs, hi;
    int          xs;
    e = '0;
    if (rst) begin
      m_h = 0; m_v = 0; m_f = 0; m_sel = 0; m_solid = 0;
    end else if (!en) begin
      m_h = 0; m_v = 0;
    end else begin
      if (m_h == 0 && m_v == 0) begin
        m_sel = sel; m_solid = {sr, sg, sb};
      end
      de = (m_h < 16) && (m_v < 4);
      hs = (m_h >= 18) && (m_h < 20);
      vs = (m_v == 5);
`ifdef PATTERN_GEN_SCROLL_EN
      xs = m_h + m_f;
`else
      xs = m_h;
`endif
      px = '0;
      if (de) begin
        case (m_sel)
          2'd0: px = m_solid;
          2'd1: px = bars[m_h / 2];
          2'd2: px = {3{8'(xs % 256)}};
          default: begin
            hi = ((xs / 16) % 2) != ((m_v / 16) % 2);
            px = hi ? 24'h000000 : 24'hFFFFFF;
          end
        endcase
      end
      e = {vs, hs, de, de && m_h == 0 && m_v == 0, px};
      m_h++;
      if (m_h == 24) begin
        m_h = 0; m_v++;
        if (m_v == 8) begin m_v = 0; m_f = (m_f + 1) % 256; end
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: one expected entry per edge, compared mid-cycle.
  always @(negedge clk) begin
    logic [27:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {4'b0, obs}, {4'b0, e});
    end
  end

  task automatic wait_sof(input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (vid.sof) break;
    end
    check("sof_wait", {31'b0, vid.sof}, 32'd1);
  endtask

  task automatic cap_line();
    for (int x = 0; x < 16; x++) begin
      if (x > 0) @(negedge clk);
      cap[x] = {vid.r, vid.g, vid.b};
    end
  endtask

  initial begin
    int t_hs, t_vs, vs_len, t_sof2, overlap, nz;
    logic [7:0] base, rv;
    #300000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_hs, t_vs, vs_len, t_sof2, overlap, nz;
    logic [7:0] base, rv;
    t_hs = -1; t_vs = -1; vs_len = 0; t_sof2 = -1; overlap = 0; nz = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {4'b0, obs}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_de", {31'b0, vid.de}, 32'd1);
    check("first_sof", {31'b0, vid.sof}, 32'd1);
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (vid.hs && t_hs < 0) t_hs = t;
      if (vid.vs) begin
        if (t_vs < 0) t_vs = t;
        vs_len++;
      end
      if (vid.vs && vid.de) overlap++;
      if (vid.sof && t_sof2 < 0) t_sof2 = t;
    end
    check("hs_start", t_hs, 32'd18);
    check("vs_start", t_vs, 32'd120);
    check("vs_len", vs_len, 32'd24);
    check("sof_period", t_sof2, 32'd192);
    check("de_during_vs", overlap, 32'd0);

    sel = 2'd1;
    wait_sof(400);
    cap_line();
    for (int x = 0; x < 16; x++) check("bars_px", {8'b0, cap[x]}, {8'b0, bars[x / 2]});

    sel = 2'd0; sr = 8'h10; sg = 8'h20; sb = 8'h30;
    wait_sof(400);
    check("solid_px0", {8'b0, vid.r, vid.g, vid.b}, 32'h00102030);
    repeat (52) @(negedge clk);
    sel = 2'd2;
    repeat (2) @(negedge clk);
    check("solid_after_sel", {8'b0, vid.r, vid.g, vid.b}, 32'h00102030);
    wait_sof(400);
    cap_line();
    base = cap[0][7:0];
`ifndef PATTERN_GEN_SCROLL_EN
    check("ramp_base", {24'b0, base}, 32'd0);
`endif
    for (int x = 0; x < 16; x++) begin
      rv = base + 8'(x);
      check("ramp_px", {8'b0, cap[x]}, {8'b0, rv, rv, rv});
    end

    wait_sof(400);
    repeat (29) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("disable_zero", {4'b0, obs}, 32'd0);
    repeat (8) begin
      @(negedge clk);
      if (obs != '0) nz++;
    end
    check("disable_hold", nz, 32'd0);
    en = 1'b1;
    @(negedge clk);
    check("reenable_sof_de", {30'b0, vid.sof, vid.de}, 32'd3);

    sel = 2'd3;
    wait_sof(400);
    cap_line();
    for (int x = 0; x < 16; x++) line_a[x] = cap[x];
    wait_sof(400);
    cap_line();
`ifdef PATTERN_GEN_SCROLL_EN
    for (int x = 1; x < 16; x++) check("checker_scroll", {8'b0, cap[x-1]}, {8'b0, line_a[x]});
`else
    for (int x = 0; x < 16; x++) begin
      check("checker_static", {8'b0, cap[x]}, {8'b0, line_a[x]});
      check("checker_white", {8'b0, line_a[x]}, 32'h00FFFFFF);
    end
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
